// File: rtl/ialu_issue_ctrl_if.sv
// ialu_issue_ctrl_if: ID / ALU / WB bundle of the integer ALU issue control.
// IALU_ISSUE_PERF_EN adds the performance counter outputs.
interface ialu_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [2:0]      id_ialu_ctrl;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic            id_add_op;
  logic [XLEN-1:0] id_rs1;
  logic [XLEN-1:0] id_rs2;
  logic [4:0]      id_rd;

  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [2:0]      alu_ctrl;
  logic [2:0]      alu_funct3;
  logic            alu_funct7_5;
  logic            alu_add_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_branch_taken;
  logic            alu_div_done;
  logic            alu_div_by_zero;
  logic            alu_overflow;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            wb_branch_taken;
  logic            wb_overflow;
  logic            wb_div_by_zero;
  logic            wb_err;

`ifdef IALU_ISSUE_PERF_EN
  logic [31:0]     perf_issued;
  logic [31:0]     perf_div_stall;
`endif

  modport master (
    input  id_valid, id_ialu_ctrl, id_funct3,
    input  id_funct7_5, id_add_op,
    input  id_rs1, id_rs2, id_rd,
    output id_ready,
    output alu_rs1, alu_rs2, alu_ctrl,
    output alu_funct3, alu_funct7_5, alu_add_op,
    input  alu_result, alu_branch_taken,
    input  alu_div_done, alu_div_by_zero,
    input  alu_overflow,
    output wb_valid, wb_rd, wb_result,
    output wb_branch_taken, wb_overflow,
    output wb_div_by_zero, wb_err
`ifdef IALU_ISSUE_PERF_EN
    , output perf_issued, perf_div_stall
`endif
  );

  modport slave (
    output id_valid, id_ialu_ctrl, id_funct3,
    output id_funct7_5, id_add_op,
    output id_rs1, id_rs2, id_rd,
    input  id_ready,
    input  alu_rs1, alu_rs2, alu_ctrl,
    input  alu_funct3, alu_funct7_5, alu_add_op,
    output alu_result, alu_branch_taken,
    output alu_div_done, alu_div_by_zero,
    output alu_overflow,
    input  wb_valid, wb_rd, wb_result,
    input  wb_branch_taken, wb_overflow,
    input  wb_div_by_zero, wb_err
`ifdef IALU_ISSUE_PERF_EN
    , input perf_issued, perf_div_stall
`endif
  );
endinterface

// File: rtl/ialu_issue_ctrl.sv
// ialu_issue_ctrl: EX-stage issue/collect FSM for the integer ALU.
// Optional perf counters with `define IALU_ISSUE_PERF_EN.
module ialu_issue_ctrl #(
  parameter int         XLEN        = 32,
  parameter int         DIV_TIMEOUT = 64,
  parameter logic [2:0] NOP_CTRL    = 3'b111
) (
  input  logic                CLK,
  input  logic                rst,
  ialu_issue_ctrl_if.master   bus
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_DIV = 3'b010;
  localparam logic [2:0] C_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE, EXEC, DIV_WAIT, RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  state_t          w_tgt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_ready;
  logic            w_acc;
  logic            w_resp;
  logic            w_done;
  logic            w_tmo;

  logic [XLEN-1:0] r_alu_rs1;
  logic [XLEN-1:0] r_alu_rs2;
  logic [2:0]      r_alu_ctrl;
  logic [2:0]      r_alu_funct3;
  logic            r_alu_funct7_5;
  logic            r_alu_add_op;
  logic [4:0]      r_rd;
  logic [2:0]      r_ctrl;
  logic            r_err;
  logic            r_bt;
  logic            r_dbz;

  assign w_ready   = (r_state == IDLE) ||
                     (r_state == RESP);
  assign w_acc     = bus.id_valid && w_ready;
  assign w_resp    = (r_state == RESP);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_done    = (r_state == DIV_WAIT) &&
                     bus.alu_div_done;
  assign w_tmo     = (r_state == DIV_WAIT) &&
                     (w_cnt_inc == CW'(DIV_TIMEOUT));

  // Destination state for a newly accepted op.
  always_comb begin
    w_tgt = EXEC;
    unique case (1'b1)
      bus.id_ialu_ctrl == C_ILL: w_tgt = RESP;
      bus.id_ialu_ctrl == C_DIV: w_tgt = DIV_WAIT;
      default:                   w_tgt = EXEC;
    endcase
  end

  // Next-state logic; done beats timeout in DIV_WAIT.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_acc) w_state_nxt = w_tgt;
      EXEC:     w_state_nxt = RESP;
      DIV_WAIT: if (w_done || w_tmo)
                  w_state_nxt = RESP;
      RESP:     w_state_nxt = w_acc ? w_tgt : IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, ALU control and status collection.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_alu_rs1      <= '0;
      r_alu_rs2      <= '0;
      r_alu_ctrl     <= NOP_CTRL;
      r_alu_funct3   <= '0;
      r_alu_funct7_5 <= 1'b0;
      r_alu_add_op   <= 1'b0;
      r_rd           <= '0;
      r_ctrl         <= '0;
      r_err          <= 1'b0;
      r_bt           <= 1'b0;
      r_dbz          <= 1'b0;
      r_cnt          <= '0;
    end else if (w_acc) begin
      r_alu_rs1      <= bus.id_rs1;
      r_alu_rs2      <= bus.id_rs2;
      r_alu_ctrl     <= (bus.id_ialu_ctrl == C_ILL) ?
                        NOP_CTRL : bus.id_ialu_ctrl;
      r_alu_funct3   <= bus.id_funct3;
      r_alu_funct7_5 <= bus.id_funct7_5;
      r_alu_add_op   <= bus.id_add_op;
      r_rd           <= bus.id_rd;
      r_ctrl         <= bus.id_ialu_ctrl;
      r_err          <= (bus.id_ialu_ctrl == C_ILL);
      r_bt           <= 1'b0;
      r_dbz          <= 1'b0;
      r_cnt          <= '0;
    end else begin
      unique case (r_state)
        EXEC: begin
          r_bt       <= bus.alu_branch_taken;
          r_alu_ctrl <= NOP_CTRL;
        end
        DIV_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_done) begin
            r_dbz      <= bus.alu_div_by_zero;
            r_alu_ctrl <= NOP_CTRL;
          end else if (w_tmo) begin
            r_err      <= 1'b1;
            r_alu_ctrl <= NOP_CTRL;
          end
        end
        default: r_alu_ctrl <= NOP_CTRL;
      endcase
    end
  end

  assign bus.id_ready     = w_ready;
  assign bus.alu_rs1      = r_alu_rs1;
  assign bus.alu_rs2      = r_alu_rs2;
  assign bus.alu_ctrl     = r_alu_ctrl;
  assign bus.alu_funct3   = r_alu_funct3;
  assign bus.alu_funct7_5 = r_alu_funct7_5;
  assign bus.alu_add_op   = r_alu_add_op;

  assign bus.wb_valid        = w_resp;
  assign bus.wb_rd           = w_resp ? r_rd : '0;
  assign bus.wb_result       = (w_resp && !r_err) ?
                               bus.alu_result : '0;
  assign bus.wb_branch_taken = w_resp && r_bt;
  assign bus.wb_overflow     = w_resp && !r_err &&
                               (r_ctrl == C_ADD) &&
                               bus.alu_overflow;
  assign bus.wb_div_by_zero  = w_resp &&
                               (r_ctrl == C_DIV) && r_dbz;
  assign bus.wb_err          = w_resp && r_err;

`ifdef IALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_div_stall;

  // Free-running accept and divide-stall counters.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_perf_issued    <= '0;
      r_perf_div_stall <= '0;
    end else begin
      if (w_acc)
        r_perf_issued <= r_perf_issued + 32'd1;
      if (r_state == DIV_WAIT)
        r_perf_div_stall <= r_perf_div_stall + 32'd1;
    end
  end

  assign bus.perf_issued    = r_perf_issued;
  assign bus.perf_div_stall = r_perf_div_stall;
`endif
endmodule
